apb_controller: RTL and testbench
=================================

APB_CONTROLLER -- requirements
Module: apb_controller

Interface
REQ-001 SHALL have port hclk, input, 1 bit: single clock, rising-edge.
REQ-002 SHALL have port hresetn, input, 1 bit: reset, asynchronous, active-high (1 = reset asserted).
REQ-003 SHALL have port valid, input, 1 bit: registered AHB transfer-valid from the AHB slave stage.
REQ-004 SHALL have port hwritereg, input, 1 bit: registered hwrite, aligned with valid.
REQ-005 SHALL have ports haddr1 and haddr2, inputs, 32 bits each: address delayed 1 and 2 cycles.
REQ-006 SHALL have port hwdata1, input, 32 bits: write data delayed 1 cycle.
REQ-007 SHALL have port tempselx, input, 3 bits: registered one-hot peripheral select, aligned with haddr1.
REQ-008 SHALL have port pwrite, output, 1 bit: APB write strobe.
REQ-009 SHALL have port penable, output, 1 bit: APB enable.
REQ-010 SHALL have port pselx, output, 3 bits: APB one-hot select.
REQ-011 SHALL have port paddr, output, 32 bits: APB address.
REQ-012 SHALL have port pwdata, output, 32 bits: APB write data.
REQ-013 SHALL have port hreadyout, output, 1 bit: AHB ready toward master.
REQ-014 SHALL have port pready, input, 1 bit: APB slave ready; present only with APB_PREADY_EN.

Function
REQ-015 SHALL implement FSM with states ST_IDLE, ST_READ, ST_RENABLE, ST_WWAIT, ST_WRITE, ST_WENABLE; 3-bit encoding.
REQ-016 SHALL drive all outputs from flops, with no combinational path from input to output.
REQ-017 SHALL, in ST_IDLE, on valid=1 and hwritereg=0, go to ST_READ and latch paddr=haddr1, pselx=tempselx, pwrite=0.
REQ-018 SHALL, in ST_IDLE, on valid=1 and hwritereg=1, go to ST_WWAIT and latch tempselx into an internal select register.
REQ-019 SHALL, in ST_IDLE, on valid=0, stay in ST_IDLE with pselx=0, penable=0, hreadyout=1.
REQ-020 SHALL move ST_WWAIT to ST_WRITE unconditionally, latching paddr=haddr2, pwdata=hwdata1, pselx=select register, pwrite=1.
REQ-021 SHALL move ST_READ to ST_RENABLE and ST_WRITE to ST_WENABLE unconditionally, setting penable=1.
REQ-022 SHALL hold penable=0 with pselx nonzero in ST_READ and ST_WRITE (APB setup phase).
REQ-023 SHALL, on access completion in ST_RENABLE or ST_WENABLE, go to ST_IDLE and clear pselx, penable and pwrite.
REQ-024 SHALL hold hreadyout=0 in ST_WWAIT, ST_READ, ST_WRITE, ST_RENABLE and ST_WENABLE, and drive hreadyout=1 only in ST_IDLE.
REQ-025 SHALL hold paddr, pwdata and pwrite stable from the setup phase through the end of the access phase.
REQ-026 SHALL leave paddr and pwdata at their last values in ST_IDLE.
REQ-027 SHALL sample valid only in ST_IDLE; valid in any other state SHALL be ignored.
REQ-028 SHALL treat tempselx=000 (unmapped address) as a normal transfer with pselx=000; the FSM SHALL still sequence and the transfer SHALL not hang.
REQ-029 SHALL give read latency of 3 cycles and write latency of 4 cycles from valid sampled to return to ST_IDLE, without wait states.

Reset
REQ-030 SHALL, while hresetn=1, force ST_IDLE, pwrite=0, penable=0, pselx=000, paddr=0, pwdata=0, hreadyout=1, select register=000, immediately and independent of hclk.
REQ-031 SHALL, on reset mid-transfer, abort the transfer with no completion, and SHALL sample valid in ST_IDLE on the first rising edge after deassertion.

Configuration
REQ-032 SHALL, with APB_PREADY_EN defined, include the pready port and complete an access phase only on a clock edge with pready=1, holding the ENABLE state and all APB outputs otherwise.
REQ-033 SHALL, without APB_PREADY_EN, omit the pready port and complete every access phase after exactly one cycle.

Verification
REQ-034 SHALL verify a read: valid=1, hwritereg=0, haddr1=8000_0010, tempselx=001 -> next cycle paddr=8000_0010, pselx=001, penable=0; then penable=1; then ST_IDLE with hreadyout=1.
REQ-035 SHALL verify a write: valid=1, hwritereg=1, then haddr2=8400_0004, hwdata1=DEAD_BEEF -> setup phase pwrite=1, pselx=010, pwdata=DEAD_BEEF, followed by one enable cycle.
REQ-036 SHALL verify that valid held at 1 during a transfer causes no state change until ST_IDLE, and a second read then starts.
REQ-037 SHALL verify that hresetn asserted while in ST_WENABLE drives all outputs to reset values with no clock edge, and that the FSM restarts from ST_IDLE.
REQ-038 SHALL verify, with APB_PREADY_EN, that pready=0 for 3 cycles during RENABLE holds penable=1 for 4 cycles with paddr stable.
REQ-039 SHALL verify that tempselx=000 produces pselx=000 throughout and a return to ST_IDLE in 3 cycles.

Source files
------------

// File: rtl/apb_controller.sv
// AHB-to-APB bridge controller: sequences the APB setup/enable phases from registered AHB controls.
// Optional feature: define APB_PREADY_EN to add the pready port and APB slave wait states.
module apb_controller (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        valid,
  input  logic        hwritereg,
  input  logic [31:0] haddr1,
  input  logic [31:0] haddr2,
  input  logic [31:0] hwdata1,
  input  logic [2:0]  tempselx,
`ifdef APB_PREADY_EN
  input  logic        pready,
`endif
  output logic        pwrite,
  output logic        penable,
  output logic [2:0]  pselx,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  output logic        hreadyout
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_RENABLE = 3'd2,
    ST_WWAIT   = 3'd3,
    ST_WRITE   = 3'd4,
    ST_WENABLE = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  sel_reg, sel_reg_nxt;
  logic        pwrite_nxt, penable_nxt, hreadyout_nxt;
  logic [2:0]  pselx_nxt;
  logic [31:0] paddr_nxt, pwdata_nxt;
  logic        access_done;

`ifdef APB_PREADY_EN
  assign access_done = pready;
`else
  assign access_done = 1'b1;
`endif

  // Next-state and next-output values are computed together so every output comes straight from a flop.
  always_comb begin
    state_nxt     = state;
    sel_reg_nxt   = sel_reg;
    pwrite_nxt    = pwrite;
    penable_nxt   = penable;
    pselx_nxt     = pselx;
    paddr_nxt     = paddr;
    pwdata_nxt    = pwdata;
    hreadyout_nxt = hreadyout;

    case (state)
      ST_IDLE: begin
        if (valid && !hwritereg) begin
          state_nxt     = ST_READ;
          paddr_nxt     = haddr1;
          pselx_nxt     = tempselx;
          pwrite_nxt    = 1'b0;
          penable_nxt   = 1'b0;
          hreadyout_nxt = 1'b0;
        end else if (valid && hwritereg) begin
          // Write data arrives one cycle after the address, so hold the select until it does.
          state_nxt     = ST_WWAIT;
          sel_reg_nxt   = tempselx;
          pselx_nxt     = '0;
          penable_nxt   = 1'b0;
          hreadyout_nxt = 1'b0;
        end else begin
          pselx_nxt     = '0;
          penable_nxt   = 1'b0;
          hreadyout_nxt = 1'b1;
        end
      end
      ST_WWAIT: begin
        state_nxt     = ST_WRITE;
        paddr_nxt     = haddr2;
        pwdata_nxt    = hwdata1;
        pselx_nxt     = sel_reg;
        pwrite_nxt    = 1'b1;
        penable_nxt   = 1'b0;
        hreadyout_nxt = 1'b0;
      end
      ST_READ: begin
        state_nxt   = ST_RENABLE;
        penable_nxt = 1'b1;
      end
      ST_WRITE: begin
        state_nxt   = ST_WENABLE;
        penable_nxt = 1'b1;
      end
      ST_RENABLE, ST_WENABLE: begin
        if (access_done) begin
          state_nxt     = ST_IDLE;
          pselx_nxt     = '0;
          penable_nxt   = 1'b0;
          pwrite_nxt    = 1'b0;
          hreadyout_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt     = ST_IDLE;
        pselx_nxt     = '0;
        penable_nxt   = 1'b0;
        pwrite_nxt    = 1'b0;
        hreadyout_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge hclk or posedge hresetn) begin
    if (hresetn) begin
      state     <= ST_IDLE;
      sel_reg   <= '0;
      pwrite    <= 1'b0;
      penable   <= 1'b0;
      pselx     <= '0;
      paddr     <= '0;
      pwdata    <= '0;
      hreadyout <= 1'b1;
    end else begin
      state     <= state_nxt;
      sel_reg   <= sel_reg_nxt;
      pwrite    <= pwrite_nxt;
      penable   <= penable_nxt;
      pselx     <= pselx_nxt;
      paddr     <= paddr_nxt;
      pwdata    <= pwdata_nxt;
      hreadyout <= hreadyout_nxt;
    end
  end

endmodule

// File: tb/tb_apb_controller.sv
// Bench for apb_controller: transaction-level expectation queue checked every cycle plus directed literal checks.
module tb_apb_controller;

  logic        hclk, hresetn, valid, hwritereg;
  logic [31:0] haddr1, haddr2, hwdata1;
  logic [2:0]  tempselx;
`ifdef APB_PREADY_EN
  logic        pready;
`endif
  logic        pwrite, penable, hreadyout;
  logic [2:0]  pselx;
  logic [31:0] paddr, pwdata;

  int n_total = 0;
  int n_pass  = 0;

  apb_controller dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .valid     (valid),
    .hwritereg (hwritereg),
    .haddr1    (haddr1),
    .haddr2    (haddr2),
    .hwdata1   (hwdata1),
    .tempselx  (tempselx),
`ifdef APB_PREADY_EN
    .pready    (pready),
`endif
    .pwrite    (pwrite),
    .penable   (penable),
    .pselx     (pselx),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .hreadyout (hreadyout)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Expected APB/AHB outputs for one clock cycle.
  typedef struct {
    logic [2:0]  sel;
    logic        en;
    logic        wr;
    logic        rdy;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t m_cur;
  exp_t m_q[$];
  bit   m_wpend;
  logic [2:0] m_wsel;

  // A sampled transfer expands into the list of per-cycle bus values it must produce.
  always @(posedge hclk or posedge hresetn) begin
    if (hresetn) begin
      m_cur   = '{sel: 3'b000, en: 1'b0, wr: 1'b0, rdy: 1'b1, addr: 32'h0, data: 32'h0};
      m_q.delete();
      m_wpend = 1'b0;
    end
`ifdef APB_PREADY_EN
    else if (m_cur.en && !pready) begin
    end
`endif
    else if (m_wpend) begin
      m_cur = '{sel: m_wsel, en: 1'b0, wr: 1'b1, rdy: 1'b0, addr: haddr2, data: hwdata1};
      m_q.push_back('{sel: m_wsel, en: 1'b1, wr: 1'b1, rdy: 1'b0, addr: haddr2, data: hwdata1});
      m_q.push_back('{sel: 3'b000, en: 1'b0, wr: 1'b0, rdy: 1'b1, addr: haddr2, data: hwdata1});
      m_wpend = 1'b0;
    end else if (m_q.size() > 0) begin
      m_cur = m_q.pop_front();
    end else if (valid && !hwritereg) begin
      m_cur = '{sel: tempselx, en: 1'b0, wr: 1'b0, rdy: 1'b0, addr: haddr1, data: m_cur.data};
      m_q.push_back('{sel: tempselx, en: 1'b1, wr: 1'b0, rdy: 1'b0, addr: haddr1, data: m_cur.data});
      m_q.push_back('{sel: 3'b000, en: 1'b0, wr: 1'b0, rdy: 1'b1, addr: haddr1, data: m_cur.data});
    end else if (valid && hwritereg) begin
      m_wsel  = tempselx;
      m_wpend = 1'b1;
      m_cur.rdy = 1'b0;
    end
  end

  always @(negedge hclk) begin
    chk("m_pselx",     {29'd0, pselx},     {29'd0, m_cur.sel});
    chk("m_penable",   {31'd0, penable},   {31'd0, m_cur.en});
    chk("m_pwrite",    {31'd0, pwrite},    {31'd0, m_cur.wr});
    chk("m_hreadyout", {31'd0, hreadyout}, {31'd0, m_cur.rdy});
    chk("m_paddr",     paddr,              m_cur.addr);
    chk("m_pwdata",    pwdata,             m_cur.data);
  end

  task automatic tick();
    @(posedge hclk);
    #2;
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cycles;
    hresetn = 1'b1; valid = 1'b0; hwritereg = 1'b0;
    haddr1 = '0; haddr2 = '0; hwdata1 = '0; tempselx = '0;
`ifdef APB_PREADY_EN
    pready = 1'b1;
`endif
    tick(); tick();
    chk("rst_hreadyout", {31'd0, hreadyout}, 32'd1);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_pselx", {29'd0, pselx}, 32'd0);
    hresetn = 1'b0;
    tick();

    // Single read
    valid = 1'b1; hwritereg = 1'b0; haddr1 = 32'h8000_0010; tempselx = 3'b001;
    tick();
    valid = 1'b0;
    chk("rd_setup_paddr", paddr, 32'h8000_0010);
    chk("rd_setup_pselx", {29'd0, pselx}, 32'd1);
    chk("rd_setup_penable", {31'd0, penable}, 32'd0);
    chk("rd_setup_hready", {31'd0, hreadyout}, 32'd0);
    tick();
    chk("rd_enable_penable", {31'd0, penable}, 32'd1);
    tick();
    chk("rd_done_hready", {31'd0, hreadyout}, 32'd1);
    chk("rd_done_pselx", {29'd0, pselx}, 32'd0);
    chk("rd_done_paddr_kept", paddr, 32'h8000_0010);

    // Single write
    valid = 1'b1; hwritereg = 1'b1; haddr1 = 32'h8400_0004; tempselx = 3'b010;
    tick();
    valid = 1'b0; haddr2 = 32'h8400_0004; hwdata1 = 32'hDEAD_BEEF;
    chk("wr_wait_hready", {31'd0, hreadyout}, 32'd0);
    chk("wr_wait_pselx", {29'd0, pselx}, 32'd0);
    tick();
    chk("wr_setup_pwrite", {31'd0, pwrite}, 32'd1);
    chk("wr_setup_pselx", {29'd0, pselx}, 32'd2);
    chk("wr_setup_pwdata", pwdata, 32'hDEAD_BEEF);
    chk("wr_setup_paddr", paddr, 32'h8400_0004);
    chk("wr_setup_penable", {31'd0, penable}, 32'd0);
    tick();
    chk("wr_enable_penable", {31'd0, penable}, 32'd1);
    tick();
    chk("wr_done_hready", {31'd0, hreadyout}, 32'd1);
    chk("wr_done_pwrite", {31'd0, pwrite}, 32'd0);

    // valid held high through a read, then a second read starts
    valid = 1'b1; hwritereg = 1'b0; haddr1 = 32'h1000_0000; tempselx = 3'b100;
    tick();
    haddr1 = 32'h2000_0000;
    tick();
    chk("hold_enable_paddr", paddr, 32'h1000_0000);
    tick();
    chk("hold_idle_hready", {31'd0, hreadyout}, 32'd1);
    tick();
    valid = 1'b0;
    chk("hold_second_paddr", paddr, 32'h2000_0000);
    chk("hold_second_penable", {31'd0, penable}, 32'd0);
    tick(); tick();

    // Reset asserted in the write enable phase, between clock edges
    valid = 1'b1; hwritereg = 1'b1; haddr1 = 32'h0000_0040; tempselx = 3'b001;
    tick();
    valid = 1'b0; haddr2 = 32'h0000_0040; hwdata1 = 32'h1234_5678;
    tick(); tick();
    chk("rst_mid_penable_before", {31'd0, penable}, 32'd1);
    #1 hresetn = 1'b1;
    #1;
    chk("rst_mid_pwrite", {31'd0, pwrite}, 32'd0);
    chk("rst_mid_penable", {31'd0, penable}, 32'd0);
    chk("rst_mid_pselx", {29'd0, pselx}, 32'd0);
    chk("rst_mid_paddr", paddr, 32'h0);
    chk("rst_mid_pwdata", pwdata, 32'h0);
    chk("rst_mid_hready", {31'd0, hreadyout}, 32'd1);
    #2 hresetn = 1'b0;
    valid = 1'b1; hwritereg = 1'b0; haddr1 = 32'h0000_0080; tempselx = 3'b001;
    tick();
    valid = 1'b0;
    chk("rst_restart_pselx", {29'd0, pselx}, 32'd1);
    chk("rst_restart_paddr", paddr, 32'h0000_0080);
    tick(); tick();

    // Unmapped select still sequences
    valid = 1'b1; hwritereg = 1'b0; haddr1 = 32'hF000_0000; tempselx = 3'b000;
    tick();
    valid = 1'b0;
    chk("unmap_setup_pselx", {29'd0, pselx}, 32'd0);
    chk("unmap_setup_hready", {31'd0, hreadyout}, 32'd0);
    tick();
    chk("unmap_enable_pselx", {29'd0, pselx}, 32'd0);
    chk("unmap_enable_penable", {31'd0, penable}, 32'd1);
    tick();
    chk("unmap_done_hready", {31'd0, hreadyout}, 32'd1);

    // Directed mix, latency measured with a bounded wait
    vecs[0] = '{wr: 1'b0, sel: 3'b010, addr: 32'h8400_0100, data: 32'h0};
    vecs[1] = '{wr: 1'b1, sel: 3'b100, addr: 32'h8800_0008, data: 32'hCAFE_F00D};
    vecs[2] = '{wr: 1'b1, sel: 3'b000, addr: 32'h9000_0000, data: 32'h5555_AAAA};
    vecs[3] = '{wr: 1'b0, sel: 3'b001, addr: 32'h8000_FFFC, data: 32'h0};
    vecs[4] = '{wr: 1'b1, sel: 3'b001, addr: 32'hFFFF_FFFF, data: 32'hFFFF_FFFF};
    vecs[5] = '{wr: 1'b0, sel: 3'b100, addr: 32'h0000_0000, data: 32'h0};
    foreach (vecs[i]) begin
      valid = 1'b1; hwritereg = vecs[i].wr; haddr1 = vecs[i].addr; tempselx = vecs[i].sel;
      tick();
      valid = 1'b0; haddr2 = vecs[i].addr; hwdata1 = vecs[i].data;
      cycles = 1;
      while (hreadyout !== 1'b1 && cycles < 12) begin
        tick();
        cycles++;
      end
      chk("vec_latency", cycles, vecs[i].wr ? 32'd4 : 32'd3);
    end

`ifdef APB_PREADY_EN
    valid = 1'b1; hwritereg = 1'b0; haddr1 = 32'h8000_0200; tempselx = 3'b100;
    tick();
    valid = 1'b0;
    tick();
    pready = 1'b0;
    cycles = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (penable === 1'b1) cycles++;
      chk("wait_paddr", paddr, 32'h8000_0200);
    end
    pready = 1'b1;
    chk("wait_penable_cycles", cycles, 32'd4);
    tick();
    chk("wait_done_hready", {31'd0, hreadyout}, 32'd1);
`endif

    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
